// File: rtl/sub8_serial.sv
// Bit-serial 8-bit subtractor: diff = a - b - bin, one bit per clock, with borrow-out and signed overflow.
// Optional SUB8_ADD_MODE_EN adds an op input selecting add (op=1) or subtract (op=0).
module sub8_serial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
`ifdef SUB8_ADD_MODE_EN
    input  logic       op,
`endif
    output logic       busy,
    output logic       done,
    output logic [7:0] diff,
    output logic       bout,
    output logic       ov
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | one operand bit processed per cycle, cnt 0..7
    // DONE  | results valid for this single cycle; start here reloads
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state, state_nxt;
    logic [7:0] ra, rb, sh;
    logic [2:0] cnt;
    logic       c;
    logic       add_mode;
    logic       op_in;
    logic       load, step;
    logic       bb, s, cn;

`ifdef SUB8_ADD_MODE_EN
    assign op_in = op;
`else
    assign op_in = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == 3'd7) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Full-adder cell shared across all bits; subtraction adds the inverted subtrahend.
    assign bb = add_mode ? rb[0] : ~rb[0];
    assign s  = ra[0] ^ bb ^ c;
    assign cn = (ra[0] & bb) | (ra[0] & c) | (bb & c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra       <= 8'h00;
            rb       <= 8'h00;
            sh       <= 8'h00;
            cnt      <= 3'd0;
            c        <= 1'b0;
            add_mode <= 1'b0;
            diff     <= 8'h00;
            bout     <= 1'b0;
            ov       <= 1'b0;
        end else if (load) begin
            ra       <= a;
            rb       <= b;
            c        <= op_in ? bin : ~bin;
            add_mode <= op_in;
            cnt      <= 3'd0;
        end else if (step) begin
            ra  <= ra >> 1;
            rb  <= rb >> 1;
            sh  <= {s, sh[7:1]};
            c   <= cn;
            cnt <= cnt + 3'd1;
            // Published outputs change only on the final bit so they stay stable while running.
            if (cnt == 3'd7) begin
                diff <= {s, sh[7:1]};
                bout <= add_mode ? cn : ~cn;
                ov   <= c ^ cn;
            end
        end
    end

endmodule

// File: tb/tb_sub8_serial.sv
// Self-checking bench for sub8_serial: vector table, back-to-back starts and mid-run reset.
module tb_sub8_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       bin;
    logic       op;
    logic       busy, done;
    logic [7:0] diff;
    logic       bout, ov;

    int checks   = 0;
    int failures = 0;

    sub8_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
`ifdef SUB8_ADD_MODE_EN
        .op    (op),
`endif
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ov    (ov)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vbin;
        logic       vop;
        logic [7:0] ediff;
        logic       ebout;
        logic       eov;
    } vec_t;

    vec_t vecs[$];
    vec_t b2b[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int edges, busyn;
        bit got;
        @(negedge clk);
        a = v.va; b = v.vb; bin = v.vbin; op = v.vop; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~v.va; b = ~v.vb; bin = ~v.vbin; op = ~v.vop;
        busyn = busy ? 1 : 0;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) got = 1'b1;
            else if (busy) busyn++;
        end
        chk($sformatf("vec%0d_latency", idx), edges, 8);
        chk($sformatf("vec%0d_busy_cycles", idx), busyn, 8);
        chk($sformatf("vec%0d_busy_at_done", idx), busy, 0);
        chk($sformatf("vec%0d_diff", idx), diff, v.ediff);
        chk($sformatf("vec%0d_bout", idx), bout, v.ebout);
        chk($sformatf("vec%0d_ov", idx), ov, v.eov);
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d_done_pulse", idx), done, 0);
    endtask

    initial begin
        logic [7:0] last_diff;
        int dcount;

        //        a      b      bin   op    diff   bout  ov
        vecs.push_back('{8'h50, 8'h30, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0});
        vecs.push_back('{8'h30, 8'h50, 1'b0, 1'b0, 8'hE0, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1});
        vecs.push_back('{8'h7F, 8'hFF, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{8'h7F, 8'h80, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1});
`ifdef SUB8_ADD_MODE_EN
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0});
`endif
        vecs.push_back('{8'hA5, 8'h5A, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b1});

        b2b[0] = '{8'h10, 8'h03, 1'b0, 1'b0, 8'h0D, 1'b0, 1'b0};
        b2b[1] = '{8'h03, 8'h10, 1'b1, 1'b0, 8'hF2, 1'b1, 1'b0};
        b2b[2] = '{8'hC0, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0; op = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 8'h00);
        chk("rst_bout", bout, 0);
        chk("rst_ov", ov, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Mid-run reset: results from the last vector must vanish without a clock edge.
        @(negedge clk);
        a = 8'h50; b = 8'h30; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_busy_before", busy, 1);
        chk("abort_diff_held", diff, 8'h4B);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 8'h00);
        chk("abort_bout", bout, 0);
        chk("abort_ov", ov, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        run_vec(vecs[0], 100);
        last_diff = vecs[0].ediff;

        // Start held high with changing operands; only the operands present at accepting edges count.
        @(negedge clk);
        a = b2b[0].va; b = b2b[0].vb; bin = b2b[0].vbin; op = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_accept0_busy", busy, 1);
        for (int k = 0; k < 3; k++) begin
            for (int e = 1; e <= 8; e++) begin
                @(negedge clk);
                if (e == 8) begin
                    if (k < 2) begin
                        a = b2b[k+1].va; b = b2b[k+1].vb; bin = b2b[k+1].vbin;
                    end else begin
                        start = 1'b0;
                    end
                end else begin
                    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
                end
                @(posedge clk);
                #1;
                if (e < 8) chk($sformatf("b2b%0d_nodone_e%0d", k, e), done, 0);
                if (e == 3) chk($sformatf("b2b%0d_diff_stable", k), diff, last_diff);
            end
            chk($sformatf("b2b%0d_done", k), done, 1);
            chk($sformatf("b2b%0d_diff", k), diff, b2b[k].ediff);
            chk($sformatf("b2b%0d_bout", k), bout, b2b[k].ebout);
            chk($sformatf("b2b%0d_ov", k), ov, b2b[k].eov);
            last_diff = b2b[k].ediff;
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d_after_done", k), done, 0);
            chk($sformatf("b2b%0d_after_busy", k), busy, (k < 2) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
